// File: rtl/iis_pkg.sv
// Shared constants and types for the I2S (Philips) stereo transmitter.
package iis_pkg;

  localparam int unsigned DATA_W    = 24;  // sample width, must be <= SLOT_BITS-1
  localparam int unsigned SLOT_BITS = 32;  // bclk periods per channel slot
  localparam int unsigned BCLK_HALF = 16;  // clk_100m cycles per bclk half-period

  localparam int unsigned DIV_W = $clog2(BCLK_HALF);
  localparam int unsigned CNT_W = $clog2(SLOT_BITS);

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]  bit_cnt_t;

  // Bit driven at the fall that advances the slot counter from cnt to cnt+1.
  // Positions 1..DATA_W carry the sample MSB first; shifting past the sample
  // width yields the zero padding for positions 0 and DATA_W+1..SLOT_BITS-1.
  function automatic logic payload_bit(input sample_t s, input bit_cnt_t cnt);
    sample_t sh;
    sh = s << cnt;
    return sh[DATA_W-1];
  endfunction

endpackage

// File: rtl/iis_clk_gen.sv
// Bit-clock divider and slot counter: produces bclk, lrclk, the bclk fall
// strobe, the current slot bit position and the frame-start strobe.
module iis_clk_gen
  import iis_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  output logic     bclk_o,
  output logic     lrclk_o,
  output logic     fall_o,
  output logic     frame_start_o,
  output bit_cnt_t bit_cnt_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  bit_cnt_t         bit_cnt_q, bit_cnt_d;
  logic             div_wrap;
  logic             fall;
  logic             slot_wrap;

  // Next-state logic for divider, bclk and the slot/word-select counters
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_W'(BCLK_HALF - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    fall      = div_wrap & bclk_q;
    slot_wrap = (bit_cnt_q == CNT_W'(SLOT_BITS - 1));
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall) begin
      if (slot_wrap) begin
        bit_cnt_d = '0;
        lrclk_d   = ~lrclk_q;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset parks lrclk high so the first fall starts a left slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
      bit_cnt_q <= CNT_W'(SLOT_BITS - 1);
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Output strobes and registered clocks
  always_comb begin
    bclk_o        = bclk_q;
    lrclk_o       = lrclk_q;
    bit_cnt_o     = bit_cnt_q;
    fall_o        = fall;
    frame_start_o = fall & slot_wrap & lrclk_q;
  end

endmodule

// File: rtl/iis_tx.sv
// I2S (Philips format) master transmitter: captures a stereo sample pair at
// each frame start and shifts it out MSB first, one bclk after each lrclk edge.
module iis_tx
  import iis_pkg::*;
(
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ldata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              en,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata_o
);

  logic     fall;
  logic     frame_start;
  bit_cnt_t bit_cnt;

  sample_t  l_reg_q, l_reg_d;
  sample_t  r_reg_q, r_reg_d;
  logic     en_frame_q, en_frame_d;
  logic     sdata_q, sdata_d;

  iis_clk_gen u_clk_gen (
    .clk_i         (clk_100m),
    .rst_ni        (rst_n),
    .bclk_o        (bclk),
    .lrclk_o       (lrclk),
    .fall_o        (fall),
    .frame_start_o (frame_start),
    .bit_cnt_o     (bit_cnt)
  );

  // Capture at frame start; serialise on every bclk fall
  always_comb begin
    l_reg_d    = l_reg_q;
    r_reg_d    = r_reg_q;
    en_frame_d = en_frame_q;
    sdata_d    = sdata_q;
    if (frame_start) begin
      l_reg_d    = ldata;
      r_reg_d    = rdata;
      en_frame_d = en;
    end
    // At the frame-start fall bit_cnt is SLOT_BITS-1, so the payload is padding
    // and the stale en_frame_q/sample registers are never observed.
    if (fall) begin
      sdata_d = en_frame_q & payload_bit(lrclk ? r_reg_q : l_reg_q, bit_cnt);
    end
  end

  // Capture and output registers
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      l_reg_q    <= '0;
      r_reg_q    <= '0;
      en_frame_q <= 1'b0;
      sdata_q    <= 1'b0;
    end else begin
      l_reg_q    <= l_reg_d;
      r_reg_q    <= r_reg_d;
      en_frame_q <= en_frame_d;
      sdata_q    <= sdata_d;
    end
  end

  assign sdata_o = sdata_q;

endmodule

// File: tb/tb_iis_tx.sv
// Scoreboard bench for iis_tx: stimulus pushes per-frame expected bits, a
// clocked monitor pops them at each bclk rise and also checks clock timing.
module tb_iis_tx;

  localparam int NF = 8;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic [23:0] ldata, rdata;
  logic        en;
  logic        bclk, lrclk, sdata_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic bitv;
    logic lr;
    int   k;
  } exp_t;
  exp_t sb[$];

  // Frame table: left, right, enable
  logic [23:0] tl [NF] = '{24'hA5C3F0, 24'h800000, 24'h123456, 24'h5A5A5A,
                           24'h000001, 24'h800000, 24'hA5C3F0, 24'h00FF00};
  logic [23:0] tr [NF] = '{24'h0F1E2D, 24'hFFFFFF, 24'h89ABCD, 24'hC3C3C3,
                           24'h7FFFFF, 24'hFFFFFF, 24'h0F1E2D, 24'hF0000F};
  logic        te [NF] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk_100m = ~clk_100m;

  iis_tx dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .ldata    (ldata),
    .rdata    (rdata),
    .en       (en),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata_o  (sdata_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected slot contents: bit 0 and bits 25..31 padding, bits 1..24 MSB first
  task automatic push_frame(input logic [23:0] l, input logic [23:0] r, input logic e);
    logic [23:0] s, sh;
    exp_t        x;
    for (int ch = 0; ch < 2; ch++) begin
      s = (ch == 1) ? r : l;
      for (int k = 0; k < 32; k++) begin
        x.lr = (ch == 1);
        x.k  = k;
        x.bitv = 1'b0;
        if (e && k >= 1 && k <= 24) begin
          sh     = s << (k - 1);
          x.bitv = sh[23];
        end
        sb.push_back(x);
      end
    end
  endtask

  task automatic set_frame(input int i);
    ldata = tl[i];
    rdata = tr[i];
    en    = te[i];
    push_frame(tl[i], tr[i], te[i]);
  endtask

  // Wait for lrclk to reach level via an edge, bounded by a cycle budget
  task automatic wait_lr(input logic level);
    logic p;
    bit   ok;
    ok = 1'b0;
    p  = lrclk;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_100m);
      #2;
      if (lrclk == level && p != level) begin
        ok = 1'b1;
        break;
      end
      p = lrclk;
    end
    if (!ok) check("lrclk_edge_timeout", 32'd0, 32'd1);
  endtask

  // Monitor state
  int   cyc, last_rise, last_lf, fall_cnt, pos;
  bit   rise_v, lr_v, lf_v, active;
  logic prev_b, prev_lr, prev_sd, mon_lr;
  logic rose, fell;
  exp_t e;

  always @(posedge clk_100m) begin
    #1;
    if (!rst_n) begin
      cyc = 0; last_rise = 0; last_lf = 0; fall_cnt = 0; pos = 0;
      rise_v = 0; lr_v = 0; lf_v = 0; active = 0;
      prev_b = bclk; prev_lr = lrclk; prev_sd = sdata_o; mon_lr = lrclk;
    end else begin
      cyc++;
      rose = bclk && !prev_b;
      fell = !bclk && prev_b;
      if (rose) begin
        if (rise_v) check("bclk_period", cyc - last_rise, 32);
        rise_v    = 1;
        last_rise = cyc;
        if (lrclk != mon_lr) pos = 0;
        else pos++;
        mon_lr = lrclk;
        if (pos == 0 && !lrclk) active = (sb.size() >= 64);
        if (active) begin
          if (sb.size() == 0) begin
            active = 0;
          end else begin
            e = sb.pop_front();
            check($sformatf("sdata %s bit %0d", e.lr ? "right" : "left", e.k), sdata_o, e.bitv);
          end
        end
      end
      if (fell) begin
        if (rise_v) check("bclk_high_time", cyc - last_rise, 16);
        fall_cnt++;
      end
      if (lrclk != prev_lr) begin
        check("lrclk_on_bclk_fall", fell, 1);
        if (lr_v) check("falls_per_lrclk_level", fall_cnt, 32);
        lr_v     = 1;
        fall_cnt = 0;
        if (!lrclk) begin
          if (lf_v) check("frame_period", cyc - last_lf, 2048);
          else check("first_frame_start", cyc, 32);
          lf_v    = 1;
          last_lf = cyc;
        end
      end
      if (sdata_o != prev_sd) check("sdata_on_bclk_fall", fell, 1);
      prev_b  = bclk;
      prev_lr = lrclk;
      prev_sd = sdata_o;
    end
  end

  initial begin
    rst_n = 1'b0;
    set_frame(0);
    repeat (3) @(posedge clk_100m);
    #1;
    check("reset_bclk", bclk, 0);
    check("reset_lrclk", lrclk, 1);
    check("reset_sdata", sdata_o, 0);
    @(negedge clk_100m);
    rst_n = 1'b1;

    // Each new frame is loaded at the right-slot start of the previous one,
    // so the right channel changes mid-frame without affecting it.
    for (int i = 1; i <= 5; i++) begin
      wait_lr(1'b1);
      set_frame(i);
    end

    // Frame 5 (right = FFFFFF) in progress: reset part-way through bit 10
    wait_lr(1'b0);
    wait_lr(1'b1);
    repeat (340) @(posedge clk_100m);
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_bclk", bclk, 0);
    check("midframe_reset_lrclk", lrclk, 1);
    check("midframe_reset_sdata", sdata_o, 0);
    sb.delete();
    set_frame(6);
    repeat (5) @(negedge clk_100m);
    rst_n = 1'b1;

    wait_lr(1'b1);
    set_frame(7);
    wait_lr(1'b0);
    wait_lr(1'b0);
    repeat (40) @(posedge clk_100m);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iis_tx.md
Name: iis_tx

Overview:
- I2S (Philips format) master transmitter for 24-bit stereo audio, clocked from the 100 MHz system clock.
- Generates bit clock (bclk) and word-select clock (lrclk) by division, then serialises the left and right samples onto sdata_o.
- Sits between the audio sample source and an external DAC/codec.

Parameters:
- BCLK_HALF, 16: clk_100m cycles per bclk half-period. bclk = 100 MHz / 32 = 3.125 MHz.
- SLOT_BITS, 32: bclk periods per channel slot. A frame is 64 bclk, giving fs of about 48.8 kHz.
- DATA_W, 24: sample width. Must be ≤ SLOT_BITS-1.

Ports:
- clk_100m  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ldata  in  24  left sample, two's complement.
- rdata  in  24  right sample, two's complement.
- en  in  1  transmit enable.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata_o  out  1  serial data, MSB first.

Behaviour:
- Reset (async, rst_n=0): div_cnt=0, bclk=0, lrclk=1, bit_cnt=SLOT_BITS-1, shift regs=0, sdata_o=0. All outputs are registered; there are no combinational paths from inputs to outputs.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 and wraps.
  - In the cycle div_cnt==BCLK_HALF-1, bclk toggles.
  - A "fall event" is the cycle in which bclk is updated 1->0.
  - Duty cycle is exactly 50%. The clocks always run, independent of en.
- Slot counter:
  - On each fall event, bit_cnt increments modulo SLOT_BITS.
  - When it wraps to 0, lrclk toggles in the same cycle.
  - Consequently lrclk and sdata_o change only on falling bclk edges, and the receiver samples on rising edges.
- Frame start: a fall event where bit_cnt wraps to 0 and lrclk goes 1->0. The first frame start occurs at the 32nd rising clk_100m edge after rst_n deasserts.
- Capture at frame start:
  - ldata and rdata are latched into l_reg and r_reg together.
  - en is latched into en_frame.
  - Inputs must be stable for one clk_100m cycle around the frame start. Changes at any other time do not affect the frame in progress.
- Serialisation (Philips one-bit delay): on each fall event with new bit_cnt = k:
  - k in 1..DATA_W: sdata_o = sample[DATA_W-k], where sample is l_reg when lrclk=0 and r_reg when lrclk=1.
  - k = 0 or k > DATA_W: sdata_o = 0 (padding).
  - Result: the MSB appears one bclk after each lrclk edge, and bits 25..31 of each slot are 0.
- en:
  - en_frame=0 forces sdata_o=0 for the whole frame.
  - Deasserting en mid-frame does not truncate the frame; the change takes effect at the next frame start.
- Reset mid-frame returns immediately to reset state. The first frame after reset is a full frame.
- Frame period = 2*SLOT_BITS*2*BCLK_HALF = 2048 clk_100m cycles.

Decomposition:
- Shared package iis_pkg: DATA_W, SLOT_BITS, BCLK_HALF defaults, and a sample_t typedef (logic [DATA_W-1:0]).
- Sub-module iis_clk_gen: divider plus slot counter. Outputs bclk, lrclk, a fall-event strobe, bit_cnt and a frame_start strobe.
- Top iis_tx: instantiates iis_clk_gen and holds the capture registers and serialiser.

Test Plan:
- Reset release, then free run:
  - bclk period is 32 clk_100m cycles, high for 16.
  - lrclk period is 2048 cycles; the first 1->0 transition is 32 cycles after reset release.
  - Exactly 32 bclk falls per lrclk level.
- ldata=24'hA5C3F0, rdata=24'h0F1E2D, en=1:
  - Left slot bits 1..24 are 101001011100001111110000; right slot bits 1..24 are 000011110001111000101101.
  - Bit 0 and bits 25..31 of each slot are 0.
  - All transitions coincide with bclk falls.
- Data changed on every lrclk rising edge (random values):
  - Each frame transmits the values present at its frame start.
  - A right-channel change mid-frame does not appear until the next frame.
- ldata=24'h800000, rdata=24'hFFFFFF:
  - A single 1 at left bit 1.
  - Right bits 1..24 are all 1, bit 25 is 0.
- en=0 for a frame:
  - sdata_o=0 throughout.
  - en dropped mid-frame still completes the frame.
  - Re-enable takes effect at the next frame start.
- rst_n pulsed low mid-right-slot:
  - Outputs are immediately bclk=0, lrclk=1, sdata_o=0.
  - Restart timing matches the power-up scenario.
